mem_responder: RTL and testbench



---
 rtl/mem_responder_pkg.sv | 17 +
 rtl/mem_responder_if.sv | 32 +++
 rtl/mem_responder_imem_array.sv | 29 ++
 rtl/mem_responder.sv | 95 +++++++++
 tb/tb_mem_responder.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_responder_pkg.sv
// Shared types and default widths for the HMMM memory responder.
// The store holds 2**ADDR_W words of {hi field, lo byte}.
package mem_responder_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_HI_W   = 7;
  localparam int DEF_LO_W   = 8;
  localparam int DEF_DEPTH  = 1 << DEF_ADDR_W;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD_HI = 2'd1,
    LOAD_LO = 2'd2,
    RUN     = 2'd3
  } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// Core bus (minus the bidirectional data byte) plus the external program-load port.
// The master side is the core/loader; the slave side is the responder.
interface mem_responder_if #(
  parameter int ADDR_W = mem_responder_pkg::DEF_ADDR_W,
  parameter int HI_W   = mem_responder_pkg::DEF_HI_W,
  parameter int LO_W   = mem_responder_pkg::DEF_LO_W
) ();

  logic              MemWrite;
  logic [ADDR_W-1:0] Adr;
  logic [HI_W-1:0]   MemData1;

  logic              load_start;
  logic              load_valid;
  logic [LO_W-1:0]   load_byte;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   load_count;
  logic              cpu_reset;

  modport master (
    output MemWrite, Adr, load_start, load_valid, load_byte, load_last,
    input  MemData1, load_ready, load_done, load_count, cpu_reset
  );

  modport slave (
    input  MemWrite, Adr, load_start, load_valid, load_byte, load_last,
    output MemData1, load_ready, load_done, load_count, cpu_reset
  );

endinterface

// File: rtl/mem_responder_imem_array.sv
// Unified instruction/data store: asynchronous read, ph2-latched write with
// independent hi-field and lo-byte enables.
module imem_array #(
  parameter int ADDR_W = mem_responder_pkg::DEF_ADDR_W,
  parameter int HI_W   = mem_responder_pkg::DEF_HI_W,
  parameter int LO_W   = mem_responder_pkg::DEF_LO_W
) (
  input  logic                 ph2,
  input  logic                 we_hi,
  input  logic                 we_lo,
  input  logic [ADDR_W-1:0]    waddr,
  input  logic [HI_W+LO_W-1:0] wdata,
  input  logic [ADDR_W-1:0]    raddr,
  output logic [HI_W+LO_W-1:0] rdata
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int WORD_W = HI_W + LO_W;

  logic [WORD_W-1:0] mem [DEPTH];

  always_ff @(posedge ph2) begin
    if (we_hi) mem[waddr][WORD_W-1:LO_W] <= wdata[WORD_W-1:LO_W];
    if (we_lo) mem[waddr][LO_W-1:0]      <= wdata[LO_W-1:0];
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: serves core reads/writes and runs the byte-stream
// program loader that holds the core in reset until the store is filled.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int HI_W   = DEF_HI_W,
  parameter int LO_W   = DEF_LO_W
) (
  input  logic            ph1,
  input  logic            ph2,
  input  logic            reset,
  mem_responder_if.slave  bus,
  inout  wire [LO_W-1:0]  MemData2
);

  localparam int WORD_W = HI_W + LO_W;

  // *_m: ph2 master latch, *_q: ph1 slave (visible) copy
  state_t            state_m, state_q;
  logic [ADDR_W-1:0] addr_m, addr_q;
  logic [ADDR_W:0]   count_m, count_q;
  logic [HI_W-1:0]   hi_m, hi_q;
  logic              ready_q, done_q, cpurst_q;

  logic              xfer, last_addr;
  logic              load_we, core_we;
  logic [ADDR_W-1:0] waddr;
  logic [WORD_W-1:0] wdata, rdata;

  assign xfer      = bus.load_valid & ready_q;
  assign last_addr = (addr_q == {ADDR_W{1'b1}});

  always_ff @(posedge ph2) begin
    if (reset) begin
      state_m <= IDLE;
      addr_m  <= '0;
      count_m <= '0;
      hi_m    <= '0;
    end else if (bus.load_start) begin
      // restart wins over any transfer in the same cycle
      state_m <= LOAD_HI;
      addr_m  <= '0;
      count_m <= '0;
      hi_m    <= '0;
    end else begin
      case (state_q)
        LOAD_HI: if (xfer) begin
          hi_m    <= bus.load_byte[HI_W-1:0];
          state_m <= LOAD_LO;
        end
        LOAD_LO: if (xfer) begin
          count_m <= count_q + 1'b1;
          addr_m  <= last_addr ? addr_q : addr_q + 1'b1;
          state_m <= (bus.load_last || last_addr) ? RUN : LOAD_HI;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge ph1) begin
    state_q  <= state_m;
    addr_q   <= addr_m;
    count_q  <= count_m;
    hi_q     <= hi_m;
    ready_q  <= (state_m == LOAD_HI) || (state_m == LOAD_LO);
    done_q   <= (state_m == RUN);
    cpurst_q <= (state_m != RUN);
  end

  assign load_we = (state_q == LOAD_LO) && xfer && !bus.load_start && !reset;
  assign core_we = (state_q == RUN) && bus.MemWrite && !reset;

  assign waddr = load_we ? addr_q : bus.Adr;
  assign wdata = load_we ? {hi_q, bus.load_byte} : {hi_q, MemData2};

  imem_array #(.ADDR_W(ADDR_W), .HI_W(HI_W), .LO_W(LO_W)) u_imem (
    .ph2   (ph2),
    .we_hi (load_we),
    .we_lo (load_we | core_we),
    .waddr (waddr),
    .wdata (wdata),
    .raddr (bus.Adr),
    .rdata (rdata)
  );

  assign bus.MemData1   = rdata[WORD_W-1:LO_W];
  assign MemData2       = bus.MemWrite ? {LO_W{1'bz}} : rdata[LO_W-1:0];
  assign bus.load_ready = ready_q;
  assign bus.load_done  = done_q;
  assign bus.load_count = count_q;
  assign bus.cpu_reset  = cpurst_q;

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: stimulus queues expected observations,
// a monitor compares them against the DUT in the low phase after ph1.
module tb_mem_responder;

  localparam int K_MD1 = 0, K_MD2 = 1, K_CNT = 2, K_RDY = 3, K_DONE = 4, K_CRST = 5;

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } item_t;

  logic       ph1, ph2, reset;
  logic       md2_en;
  logic [7:0] md2_val;
  wire  [7:0] md2;

  item_t sbq[$];
  int    checks = 0;
  int    errors = 0;

  mem_responder_if bus ();

  assign md2 = md2_en ? md2_val : 8'bzzzzzzzz;

  mem_responder dut (
    .ph1      (ph1),
    .ph2      (ph2),
    .reset    (reset),
    .bus      (bus),
    .MemData2 (md2)
  );

  initial begin
    ph1 = 0;
    ph2 = 0;
    forever begin
      #1 ph1 = 1;
      #5 ph1 = 0;
      #5 ph2 = 1;
      #5 ph2 = 0;
      #4;
    end
  end

  initial begin
    forever begin
      item_t       it;
      logic [15:0] act;
      @(negedge ph1);
      while (sbq.size() > 0) begin
        it = sbq.pop_front();
        case (it.kind)
          K_MD1:   act = {9'd0, bus.MemData1};
          K_MD2:   act = {8'd0, md2};
          K_CNT:   act = {7'd0, bus.load_count};
          K_RDY:   act = {15'd0, bus.load_ready};
          K_DONE:  act = {15'd0, bus.load_done};
          default: act = {15'd0, bus.cpu_reset};
        endcase
        checks++;
        if (act !== it.exp) begin
          errors++;
          $display("FAIL %s actual=%0h expected=%0h", it.name, act, it.exp);
        end
      end
    end
  end

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  task automatic expect_v(input int kind, input logic [15:0] v, input string name);
    item_t it;
    it.kind = kind;
    it.exp  = v;
    it.name = name;
    sbq.push_back(it);
  endtask

  task automatic expect_status(input logic rdy, input logic done, input logic crst,
                               input logic [8:0] cnt, input string tag);
    expect_v(K_RDY,  {15'd0, rdy},  {tag, "_ready"});
    expect_v(K_DONE, {15'd0, done}, {tag, "_done"});
    expect_v(K_CRST, {15'd0, crst}, {tag, "_cpu_reset"});
    expect_v(K_CNT,  {7'd0, cnt},   {tag, "_count"});
  endtask

  task automatic read_check(input logic [7:0] a, input logic [6:0] hi, input logic [7:0] lo,
                            input string tag);
    bus.Adr      = a;
    bus.MemWrite = 0;
    md2_en       = 0;
    #1;
    expect_v(K_MD1, {9'd0, hi}, {tag, "_md1"});
    expect_v(K_MD2, {8'd0, lo}, {tag, "_md2"});
    tick();
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last);
    bus.load_valid = 1;
    bus.load_byte  = b;
    bus.load_last  = last;
    tick();
    bus.load_valid = 0;
    bus.load_last  = 0;
  endtask

  task automatic start_load();
    bus.load_start = 1;
    tick();
    bus.load_start = 0;
  endtask

  initial begin
    logic [7:0] hb, lb;
    reset          = 1;
    bus.MemWrite   = 0;
    bus.Adr        = '0;
    bus.load_start = 0;
    bus.load_valid = 0;
    bus.load_byte  = '0;
    bus.load_last  = 0;
    md2_en         = 0;
    md2_val        = '0;
    repeat (3) tick();
    expect_status(0, 0, 1, 9'd0, "reset");
    tick();
    reset = 0;
    tick();
    expect_status(0, 0, 1, 9'd0, "idle");
    tick();

    // three-word load with a gappy middle word
    start_load();
    expect_status(1, 0, 1, 9'd0, "load_begin");
    send_byte(8'h12, 1);
    send_byte(8'h34, 0);
    expect_status(1, 0, 1, 9'd1, "after_w0");
    send_byte(8'h05, 0);
    tick();
    tick();
    expect_v(K_CNT, 16'd1, "gap_count");
    send_byte(8'h67, 0);
    send_byte(8'h7F, 0);
    send_byte(8'hAB, 1);
    expect_status(0, 1, 0, 9'd3, "load3_run");
    tick();
    expect_status(0, 1, 0, 9'd3, "load3_hold");
    read_check(8'd0, 7'h12, 8'h34, "mem0");
    read_check(8'd1, 7'h05, 8'h67, "mem1");
    read_check(8'd2, 7'h7F, 8'hAB, "mem2");

    // core write in RUN touches only the low byte
    bus.Adr      = 8'd1;
    bus.MemWrite = 1;
    md2_en       = 1;
    md2_val      = 8'hC3;
    tick();
    read_check(8'd1, 7'h05, 8'hC3, "core_wr");
    read_check(8'd2, 7'h7F, 8'hAB, "core_wr_neighbor");

    // restart from RUN, then restart again during LOAD_LO with valid high
    start_load();
    expect_status(1, 0, 1, 9'd0, "restart_run");
    send_byte(8'h11, 0);
    bus.load_start = 1;
    bus.load_valid = 1;
    bus.load_byte  = 8'h22;
    tick();
    bus.load_start = 0;
    bus.load_valid = 0;
    expect_status(1, 0, 1, 9'd0, "restart_lo");
    read_check(8'd0, 7'h12, 8'h34, "restart_nowrite");

    // full 256-word load, load_last never set
    for (int i = 0; i < 256; i++) begin
      hb = 8'(i * 3) & 8'h7F;
      lb = 8'(i) ^ 8'hA5;
      send_byte(hb, 1);
      send_byte(lb, 0);
      if (i == 254) expect_status(1, 0, 1, 9'd255, "full_254");
    end
    expect_status(0, 1, 0, 9'd256, "full_run");
    read_check(8'd0,   7'h00, 8'hA5, "full_mem0");
    read_check(8'd128, 7'h00, 8'h25, "full_mem128");
    read_check(8'd255, 7'h7D, 8'h5A, "full_mem255");

    // reset in the middle of a load
    start_load();
    send_byte(8'h3A, 0);
    send_byte(8'h5C, 0);
    send_byte(8'h41, 0);
    send_byte(8'h99, 0);
    send_byte(8'h22, 0);
    reset = 1;
    tick();
    reset = 0;
    expect_status(0, 0, 1, 9'd0, "midreset");
    read_check(8'd0, 7'h3A, 8'h5C, "midreset_mem0");
    read_check(8'd1, 7'h41, 8'h99, "midreset_mem1");
    read_check(8'd2, 7'h06, 8'hA7, "midreset_mem2");

    // MemWrite in IDLE: responder must not drive the byte, nor write it
    bus.Adr      = 8'd0;
    bus.MemWrite = 1;
    md2_en       = 1;
    md2_val      = 8'h00;
    #1;
    expect_v(K_MD2, 16'h0000, "idle_wr_no_drive");
    tick();
    read_check(8'd0, 7'h3A, 8'h5C, "idle_wr_ignored");

    tick();
    tick();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain actual=%0d expected=0", sbq.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
